// File: rtl/alu_seq_pkg.sv
// Shared definitions for the execute-stage ALU operation sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: opcode constants, FSM state encoding, ALU select words
// ordered {s4,s3,s2,s1,s0}, default MUL iteration count and a helper
// that identifies the opcodes whose carry feeds the ADC carry flag.
package alu_seq_pkg;

    localparam int MUL_STEPS_DEF = 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;
    localparam logic [2:0] OP_INC   = 3'b101;
    localparam logic [2:0] OP_ADC   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    // Select words, bit order {s4,s3,s2,s1,s0}.
    localparam logic [4:0] SEL_ADD   = 5'b00000;
    localparam logic [4:0] SEL_SUB   = 5'b01100;
    localparam logic [4:0] SEL_AND   = 5'b00001;
    localparam logic [4:0] SEL_PASSA = 5'b00010;
    localparam logic [4:0] SEL_PASSB = 5'b00011;
    localparam logic [4:0] SEL_INC   = 5'b10100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Arithmetic ops report their carry and refresh the ADC carry flag;
    // logic/pass ops and MUL leave the flag alone and report carry 0.
    function automatic logic updates_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_ADC);
    endfunction

endpackage

// File: rtl/alu_sel_decode.sv
// Opcode to ALU select decoder for the operation sequencer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   op_i      opcode of the operation in flight
//   cflag_i   stored carry flag, becomes carry-in (s2) for ADC
//   mul_bit_i current multiplier LSB; MUL adds when set, passes acc otherwise
//   sel_o     select word {s4,s3,s2,s1,s0}
module alu_sel_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       cflag_i,
    input  logic       mul_bit_i,
    output logic [4:0] sel_o
);

    always_comb begin
        sel_o = SEL_PASSA;
        case (op_i)
            OP_ADD:   sel_o = SEL_ADD;
            OP_SUB:   sel_o = SEL_SUB;
            OP_AND:   sel_o = SEL_AND;
            OP_PASSA: sel_o = SEL_PASSA;
            OP_PASSB: sel_o = SEL_PASSB;
            OP_INC:   sel_o = SEL_INC;
            OP_ADC:   sel_o = {2'b00, cflag_i, 2'b00};
            OP_MUL:   sel_o = mul_bit_i ? SEL_ADD : SEL_PASSA;
            default:  sel_o = SEL_PASSA;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time onto the external 8-bit ALU; MUL runs as shift-add.
// Latency: response valid 2 edges after the accepting edge, MUL_STEPS+1 edges for MUL.
// Backpressure: response held stable until rsp_ready; req_ready low while busy or stalled.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready/req_op/a/b request handshake and operands
//   rsp_valid/rsp_ready/data/carry response handshake and result
//   alu_a, alu_b, alu_s0..alu_s4   drive to the ALU
//   alu_o, alu_cout                ALU result and carry back
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_STEPS = MUL_STEPS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_s0,
    output logic       alu_s1,
    output logic       alu_s2,
    output logic       alu_s3,
    output logic       alu_s4,
    input  logic [7:0] alu_o,
    input  logic       alu_cout
);

    localparam int STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        mcand_q, mcand_d;
    logic [7:0]        mplier_q, mplier_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              cflag_q, cflag_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;

    logic       xfer;
    logic       busy;
    logic [7:0] acc_step;
    logic [4:0] dec_sel;
    logic [4:0] sel;

    assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign xfer      = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = (state_q == ST_EXEC) || (state_q == ST_MUL);

    // Partial-product accumulate: take the adder result only when the
    // current multiplier bit is set (the decoder selects PASSA otherwise).
    assign acc_step = mplier_q[0] ? alu_o : acc_q;

    alu_sel_decode u_sel_decode (
        .op_i      (op_q),
        .cflag_i   (cflag_q),
        .mul_bit_i (mplier_q[0]),
        .sel_o     (dec_sel)
    );

    // Outside EXEC/MUL the ALU sees zeros and a harmless pass-through.
    assign sel    = busy ? dec_sel : SEL_PASSA;
    assign alu_a  = (state_q == ST_EXEC) ? a_q : ((state_q == ST_MUL) ? acc_q : 8'h00);
    assign alu_b  = (state_q == ST_EXEC) ? b_q : ((state_q == ST_MUL) ? mcand_q : 8'h00);
    assign alu_s0 = sel[0];
    assign alu_s1 = sel[1];
    assign alu_s2 = sel[2];
    assign alu_s3 = sel[3];
    assign alu_s4 = sel[4];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        step_d      = step_q;
        cflag_d     = cflag_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_EXEC: begin
                rsp_data_d = alu_o;
                if (updates_carry(op_q)) begin
                    rsp_carry_d = alu_cout;
                    cflag_d     = alu_cout;
                end else begin
                    rsp_carry_d = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    rsp_data_d  = acc_step;
                    rsp_carry_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance only happens from IDLE or a draining RESP, so it can
        // safely override whatever those states chose above.
        if (xfer) begin
            op_d = req_op;
            a_d  = req_a;
            b_d  = req_b;
            if (req_op == OP_MUL) begin
                acc_d    = 8'h00;
                mcand_d  = req_a;
                mplier_d = req_b;
                step_d   = '0;
                state_d  = ST_MUL;
            end else begin
                state_d = ST_EXEC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= 8'h00;
            mcand_q     <= 8'h00;
            mplier_q    <= 8'h00;
            step_q      <= '0;
            cflag_q     <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            step_q      <= step_d;
            cflag_q     <= cflag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

endmodule
